// File: rtl/wb_writeback_stage_if.sv
// MEM -> WB stage interface: the MEM-side instruction fields, the hazard controls, and the WB-side register-file write triple.
// When WB_RETIRE_COUNT_EN is defined, it also carries RetireCount.
interface wb_writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              MemValid;
  logic              MemRegWrite;
  logic              MemToReg;
  logic [REG_AW-1:0] MemWriteRegister;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] MemReadData;
  logic [2:0]        LoadType;
  logic [1:0]        ByteOffset;
  logic              Stall;
  logic              Flush;

  logic              RegWrite;
  logic [REG_AW-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              WbValid;
  logic              AlignErr;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0]       RetireCount;
`endif

  // The master drives the MEM side and the hazard controls.
  modport master (
    output MemValid, MemRegWrite, MemToReg, MemWriteRegister, ALUResult,
           MemReadData, LoadType, ByteOffset, Stall, Flush,
    input  RegWrite, WriteRegister, WriteData, WbValid, AlignErr
`ifdef WB_RETIRE_COUNT_EN
    , input RetireCount
`endif
  );

  modport slave (
    input  MemValid, MemRegWrite, MemToReg, MemWriteRegister, ALUResult,
           MemReadData, LoadType, ByteOffset, Stall, Flush,
    output RegWrite, WriteRegister, WriteData, WbValid, AlignErr
`ifdef WB_RETIRE_COUNT_EN
    , output RetireCount
`endif
  );
endinterface

// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register with load extraction, $0 write suppression and stall/flush handling.
// Defining WB_RETIRE_COUNT_EN adds a free-running RetireCount of retired WB instructions.
module wb_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic               clk,
  input logic               reset_n,
  wb_writeback_stage_if.slave wb
);

  typedef enum logic [2:0] {
    LT_WORD   = 3'b000,
    LT_BYTE_S = 3'b001,
    LT_BYTE_U = 3'b010,
    LT_HALF_S = 3'b011,
    LT_HALF_U = 3'b100
  } load_type_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        ltype;
    logic [1:0]        boff;
  } mem_wb_t;

  mem_wb_t mem_wb_d, mem_wb_q;

  // NOTE: give every always_comb output a default first; a path that leaves it unassigned infers a latch.
  always_comb begin
    mem_wb_d = mem_wb_q;
    if (wb.Flush) begin
      mem_wb_d = '0;
    end else if (!wb.Stall) begin
      mem_wb_d.valid      = wb.MemValid;
      mem_wb_d.reg_write  = wb.MemRegWrite;
      mem_wb_d.mem_to_reg = wb.MemToReg;
      mem_wb_d.wreg       = wb.MemWriteRegister;
      mem_wb_d.alu        = wb.ALUResult;
      mem_wb_d.rdata      = wb.MemReadData;
      mem_wb_d.ltype      = wb.LoadType;
      mem_wb_d.boff       = wb.ByteOffset;
    end
  end

  // NOTE: flops use non-blocking assignments, so every always_ff block samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_wb_q <= '0;
    else          mem_wb_q <= mem_wb_d;
  end

  logic [DATA_W-1:0] byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_data;
  logic              is_half;

  assign byte_lane = mem_wb_q.rdata >> {mem_wb_q.boff, 3'b000};
  assign half_lane = mem_wb_q.boff[1] ? mem_wb_q.rdata[31:16] : mem_wb_q.rdata[15:0];
  assign is_half   = (mem_wb_q.ltype == LT_HALF_S) || (mem_wb_q.ltype == LT_HALF_U);

  always_comb begin
    load_data = mem_wb_q.rdata;
    unique case (load_type_e'(mem_wb_q.ltype))
      LT_BYTE_S: load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane[7:0]};
      LT_BYTE_U: load_data = {{(DATA_W-8){1'b0}}, byte_lane[7:0]};
      LT_HALF_S: load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LT_HALF_U: load_data = {{(DATA_W-16){1'b0}}, half_lane};
      default:   load_data = mem_wb_q.rdata;
    endcase
  end

  // Only a real load can be misaligned; word loads and ALU writes never check alignment.
  assign wb.AlignErr      = mem_wb_q.valid & mem_wb_q.mem_to_reg & is_half & mem_wb_q.boff[0];
  assign wb.WbValid       = mem_wb_q.valid;
  assign wb.WriteRegister = mem_wb_q.wreg;
  assign wb.WriteData     = mem_wb_q.mem_to_reg ? load_data : mem_wb_q.alu;
  assign wb.RegWrite      = mem_wb_q.valid & mem_wb_q.reg_write
                          & (mem_wb_q.wreg != '0) & ~wb.AlignErr;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_d, retire_q;

  // A flushed edge still retires the instruction currently sitting in WB.
  assign retire_d = (mem_wb_q.valid && !wb.Stall) ? retire_q + 32'd1 : retire_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retire_q <= '0;
    else          retire_q <= retire_d;
  end

  assign wb.RetireCount = retire_q;
`endif

endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
- MEM/WB pipeline register plus write-back data selection for the 5-stage MIPS pipeline.
- Drives the write port of the register file, and the RegWrite / WriteRegister / WriteData triple consumed by the WB forwarding logic in decode.
- Performs load-data extraction (byte/half, signed/unsigned) and suppresses writes to $0.
- Handles stall and flush coming from the hazard unit.

Parameters:
- DATA_W, 32, datapath width (only 32 is supported).
- REG_AW, 5, register address width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- MemValid  input  1  MEM stage holds a real instruction (not a bubble).
- MemRegWrite  input  1  instruction in MEM writes a register.
- MemToReg  input  1  1 selects load data, 0 selects ALU result.
- MemWriteRegister  input  5  destination register from MEM.
- ALUResult  input  32  ALU result carried through MEM.
- MemReadData  input  32  raw aligned word returned by data memory.
- LoadType  input  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned.
- ByteOffset  input  2  ALUResult[1:0] of the load address.
- Stall  input  1  hold the MEM/WB register contents.
- Flush  input  1  replace the captured instruction with a bubble.
- RegWrite  output  1  register-file write enable.
- WriteRegister  output  5  register-file write address.
- WriteData  output  32  register-file write data.
- WbValid  output  1  WB stage holds a valid instruction this cycle.
- AlignErr  output  1  pulse: misaligned halfword load reached WB.

Behaviour:
- Reset (reset_n low, asynchronous): all pipeline registers cleared. RegWrite=0, WriteRegister=0, WriteData=0, WbValid=0, AlignErr=0.
- Latency: 1 cycle. MEM values captured at posedge clk appear on outputs the following cycle.
- Priority per edge, highest first:
  - Flush: valid and write-enable registers cleared. Data/address registers are don't-care but cleared for determinism. Flush wins over Stall.
  - Stall (without Flush): all registers hold. Outputs repeat identically, so RegWrite may assert on consecutive cycles with the same address and data. This is legal because the register file write is idempotent.
  - Otherwise: capture MemValid, MemRegWrite, MemToReg, MemWriteRegister, ALUResult, MemReadData, LoadType, ByteOffset.
- Extraction is combinational on registered values:
  - Byte: lane selected by ByteOffset (0 selects bits 7:0), then zero- or sign-extended.
  - Half: ByteOffset[1] selects the half (0 selects bits 15:0), then extended.
  - Word: passed unchanged.
  - LoadType 101-111: treated as word.
- WriteData = MemToReg ? extracted data : ALUResult.
- Misaligned halfword: registered half load with ByteOffset[0]=1.
  - AlignErr=1, and the write is suppressed.
  - AlignErr lasts one cycle unless stalled; it holds while stalled.
- Word loads ignore ByteOffset, with no alignment check.
- RegWrite = WbValid & regMemRegWrite & (regWriteRegister != 0) & ~AlignErr. Downstream logic never sees a $0 write asserted.
- WriteRegister and WriteData always reflect the registered instruction, even when RegWrite=0.
- Reset deasserted mid-operation: the first capture happens on the next rising edge; no partial state.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- When defined: adds output RetireCount (32 bits).
  - Reset value 0.
  - Increments by 1 on each posedge where WbValid=1 and Stall=0, including Flush cycles, since the current WB instruction still retires.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Reset, then MemValid=1, MemRegWrite=1, MemToReg=0, MemWriteRegister=8, ALUResult=0x12345678 -> next cycle RegWrite=1, WriteRegister=8, WriteData=0x12345678, WbValid=1.
- Byte-load lanes: MemToReg=1, MemReadData=0x80FF7F01, LoadType=001, offsets 0/1/2/3 -> WriteData 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Same with LoadType=010 -> 0x01, 0x7F, 0xFF, 0x80.
- Half-load extension: LoadType=011, ByteOffset=2, MemReadData=0x8001FFFF -> WriteData=0xFFFF8001. ByteOffset=1 -> AlignErr=1, RegWrite=0.
- Write to $0: MemWriteRegister=0, MemRegWrite=1 -> RegWrite=0, WbValid=1.
- Stall/Flush interaction:
  - Stall held 3 cycles with new MEM inputs -> outputs unchanged for 3 cycles.
  - Stall and Flush together -> next cycle RegWrite=0, WbValid=0.
  - reset_n pulsed low mid-stall -> outputs 0 immediately, without waiting for a clock edge.
- With WB_RETIRE_COUNT_EN:
  - 10 valid instructions, 2 stall cycles and 1 bubble -> RetireCount=10.
  - Preload near wrap, then 2 retires past 0xFFFFFFFF -> RetireCount=1.
